// File: rtl/spi_frame_builder_if.sv
// Handshake/bus bundle between the frame builder and its neighbours:
// job control, byte stream in, frame + launch/complete towards the SPI master.
interface spi_frame_builder_if #(
  parameter int CTRL_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_BYTES = 64
);
  localparam int FRAME_WIDTH = CTRL_WIDTH + ADDR_WIDTH + BURST_BYTES*DATA_WIDTH;

  logic                   start;
  logic                   rw;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [15:0]            burst_count;
  logic                   din_valid;
  logic                   din_ready;
  logic [DATA_WIDTH-1:0]  din;
  logic                   spi_exe;
  logic [FRAME_WIDTH-1:0] tx_data;
  logic                   spi_done;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, rw, base_addr, burst_count, din_valid, din, spi_done,
    output din_ready, spi_exe, tx_data, busy, done
  );

  modport master (
    output start, rw, base_addr, burst_count, din_valid, din, spi_done,
    input  din_ready, spi_exe, tx_data, busy, done
  );
endinterface

// File: rtl/spi_frame_builder.sv
// Packs a byte stream into {ctrl, addr, BURST_BYTES data} frames, launches each
// with a one-cycle spi_exe and waits for spi_done before building the next.
module spi_frame_builder #(
  parameter int CTRL_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_BYTES = 64,
  parameter logic [CTRL_WIDTH-1:0] CTRL_WRITE = 8'h3a,
  parameter logic [CTRL_WIDTH-1:0] CTRL_READ  = 8'h3b
) (
  input  logic              clock,
  input  logic              reset,
  spi_frame_builder_if.slave bus
);
  localparam int HDR_W       = CTRL_WIDTH + ADDR_WIDTH;
  localparam int FRAME_WIDTH = HDR_W + BURST_BYTES*DATA_WIDTH;
  localparam int CNT_W       = $clog2(BURST_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BURST_BYTES-1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT} state_e;

  state_e                                  state_q, state_d;
  logic                                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
  logic [15:0]                             rem_q, rem_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [HDR_W-1:0]                        hdr_q, hdr_d;
  logic [BURST_BYTES-1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic                                    exe_q, exe_d;
  logic                                    rdy_q, rdy_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      exe_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      exe_q   <= exe_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.burst_count != '0) begin
            rw_d    = bus.rw;
            addr_d  = bus.base_addr;
            rem_d   = bus.burst_count;
            cnt_d   = '0;
            data_d  = '0;
            state_d = bus.rw ? S_ISSUE : S_FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (bus.din_valid && rdy_q) begin
          data_d[cnt_q] = bus.din;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BYTE) state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.spi_done) begin
          addr_d = addr_q + ADDR_WIDTH'(BURST_BYTES);
          rem_d  = rem_q - 1'b1;
          cnt_d  = '0;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = rw_q ? S_ISSUE : S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Header is stamped on the way into ISSUE so it is valid alongside spi_exe.
    if (state_d == S_ISSUE) hdr_d = {rw_d ? CTRL_READ : CTRL_WRITE, addr_d};

    exe_d  = (state_d == S_ISSUE);
    rdy_d  = (state_d == S_FILL);
    busy_d = (state_d != S_IDLE);
  end

  assign bus.tx_data   = {hdr_q, data_q};
  assign bus.spi_exe   = exe_q;
  assign bus.din_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Elaboration-time guard on the frame layout.
  if (FRAME_WIDTH != $bits(bus.tx_data)) begin : g_width_mismatch
    $error("tx_data width does not match frame layout");
  end
endmodule

// File: tb/tb_spi_frame_builder.sv
// Directed bench: stimulus pushes expected frames/done events into queues,
// a monitor pops and compares whenever the DUT presents spi_exe or done.
module tb_spi_frame_builder;
  localparam int FW = 552;

  typedef struct {
    logic [39:0]  hdr;
    logic [511:0] data;
    bit           rd;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_frame_builder_if bus ();
  spi_frame_builder dut (.clock(clk), .reset(rst_n), .bus(bus.slave));

  logic resp_sd = 1'b0, spur_sd = 1'b0;
  assign bus.spi_done = resp_sd | spur_sd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t exp_q[$];
  bit     done_q[$];   // 1: zero-burst done (start+1), 0: after last spi_done
  int     exp_exe = 0, tmo = 0, end_req = 0, gen = 0;
  int     last_sd_cyc = -100;

  // SPI master model: spi_done 20 cycles after each spi_exe, dropped across reset
  always begin : responder
    int g;
    @(negedge clk);
    if (rst_n && bus.spi_exe) begin
      g = gen;
      repeat (20) @(posedge clk);
      #1;
      if (g == gen && rst_n) begin
        resp_sd = 1'b1;
        last_sd_cyc = cyc;
        @(posedge clk); #1;
        resp_sd = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int n_cmp = 0, n_bad = 0;
  int start_cyc = -100, fill_end_cyc = -100, acc = 0, exe_total = 0, end_ack = 0;
  bit job_rw = 0, start_zero = 0, rdy_seen = 0, rst_checked = 0;
  frame_t f;
  bit d;

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (!rst_checked) begin
        chk("rst_spi_exe", bus.spi_exe, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_checked = 1;
      end
      exp_q.delete();
      done_q.delete();
      acc = 0;
    end else begin
      rst_checked = 0;
      if (cyc == start_cyc + 1 && !start_zero) begin
        chk("start_busy", bus.busy, 1);
        chk("start_din_ready", bus.din_ready, !job_rw);
      end
      if (bus.start && !bus.busy) begin
        start_cyc  = cyc;
        job_rw     = bus.rw;
        start_zero = (bus.burst_count == 16'd0);
        rdy_seen   = 0;
        acc        = 0;
      end
      if (bus.din_ready && job_rw) rdy_seen = 1;
      if (bus.din_valid && bus.din_ready) begin
        acc++;
        if (acc == 64) begin
          acc = 0;
          fill_end_cyc = cyc;
        end
      end
      if (bus.spi_exe) begin
        exe_total++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spi_exe_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          f = exp_q.pop_front();
          chk("frame_hdr", bus.tx_data[551:512], f.hdr);
          chk("frame_data", bus.tx_data[511:0], f.data);
          if (f.rd) begin
            chk("rd_exe_timing", cyc, (last_sd_cyc > start_cyc ? last_sd_cyc : start_cyc) + 1);
            chk("rd_din_ready_seen", rdy_seen, 0);
          end else begin
            chk("wr_exe_timing", cyc, fill_end_cyc + 1);
          end
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          chk("done_timing", cyc, d ? start_cyc + 1 : last_sd_cyc + 1);
          chk("done_busy", bus.busy, 0);
        end
      end
      if (end_req != end_ack) begin
        end_ack = end_req;
        chk("frames_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        chk("exe_count", exe_total, exp_exe);
        chk("timeouts", tmo, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [511:0] mk_data(int first);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[8*k +: 8] = 8'(first + k);
    return v;
  endfunction

  task automatic push_frame(logic [39:0] hdr, logic [511:0] data, bit rd);
    frame_t e;
    e.hdr = hdr; e.data = data; e.rd = rd;
    exp_q.push_back(e);
    exp_exe++;
  endtask

  task automatic start_job(bit rw, logic [31:0] base, logic [15:0] n);
    bus.start = 1'b1; bus.rw = rw; bus.base_addr = base; bus.burst_count = n;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_stream(int first, int count, bit gaps);
    bit ok;
    int w;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        bus.din_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      bus.din = 8'(first + i);
      bus.din_valid = 1'b1;
      ok = 0; w = 0;
      while (!ok && w < 300) begin
        @(negedge clk);
        ok = bus.din_ready;
        @(posedge clk); #1;
        w++;
      end
      if (!ok) begin
        tmo++;
        break;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.busy && w < 3000);
    if (bus.busy) tmo++;
    tick();
  endtask

  task automatic write_job_s1();
    push_frame(40'h3a_00000000, mk_data(0),   0);
    push_frame(40'h3a_00000040, mk_data(64),  0);
    push_frame(40'h3a_00000080, mk_data(128), 0);
    done_q.push_back(0);
    start_job(0, 32'h0, 16'd3);
    send_stream(0, 192, 0);
    wait_idle();
  endtask

  initial begin
    bus.start = 0; bus.rw = 0; bus.base_addr = '0; bus.burst_count = '0;
    bus.din_valid = 0; bus.din = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Write job, three frames back-to-back
    write_job_s1();

    // Read job with a start pulse injected during WAIT
    push_frame(40'h3b_00000000, '0, 1);
    push_frame(40'h3b_00000040, '0, 1);
    push_frame(40'h3b_00000080, '0, 1);
    done_q.push_back(0);
    start_job(1, 32'h0, 16'd3);
    repeat (5) tick();
    start_job(0, 32'h0000_5555, 16'd7);
    wait_idle();

    // Write with random valid gaps and a spurious spi_done during FILL
    push_frame(40'h3a_00001000, mk_data(8'hA5), 0);
    done_q.push_back(0);
    start_job(0, 32'h0000_1000, 16'd1);
    send_stream(8'hA5, 30, 1);
    spur_sd = 1'b1; tick(); spur_sd = 1'b0;
    send_stream(8'hA5 + 30, 34, 1);
    wait_idle();

    // Address wrap-around
    push_frame(40'h3b_FFFFFFC0, '0, 1);
    push_frame(40'h3b_00000000, '0, 1);
    done_q.push_back(0);
    start_job(1, 32'hFFFF_FFC0, 16'd2);
    wait_idle();

    // Zero-length job
    done_q.push_back(1);
    start_job(0, 32'h0000_1234, 16'd0);
    repeat (3) tick();

    // Reset in WAIT, then a fresh job
    push_frame(40'h3a_00000000, mk_data(0),   0);
    push_frame(40'h3a_00000040, mk_data(64),  0);
    push_frame(40'h3a_00000080, mk_data(128), 0);
    done_q.push_back(0);
    start_job(0, 32'h0, 16'd3);
    send_stream(0, 64, 0);
    repeat (6) tick();
    rst_n = 1'b0;
    gen++;
    exp_exe -= 2;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    write_job_s1();

    end_req++;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
